// File: rtl/bsg_zynq_uart_host_bridge.sv
// Host-side AXI-lite to UART command bridge: serializes each request into a 5-byte packet
// and collects the 4-byte read response from the inbound byte stream.
module bsg_zynq_uart_host_bridge #(
    parameter int unsigned s_axil_addr_width_p = 32,
    parameter int unsigned s_axil_data_width_p = 32,
    parameter int unsigned timeout_p           = 65536
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,

    input  logic [s_axil_addr_width_p-1:0]      s_axil_awaddr_i,
    input  logic [2:0]                          s_axil_awprot_i,
    input  logic                                s_axil_awvalid_i,
    output logic                                s_axil_awready_o,

    input  logic [s_axil_data_width_p-1:0]      s_axil_wdata_i,
    input  logic [(s_axil_data_width_p/8)-1:0]  s_axil_wstrb_i,
    input  logic                                s_axil_wvalid_i,
    output logic                                s_axil_wready_o,

    output logic [1:0]                          s_axil_bresp_o,
    output logic                                s_axil_bvalid_o,
    input  logic                                s_axil_bready_i,

    input  logic [s_axil_addr_width_p-1:0]      s_axil_araddr_i,
    input  logic [2:0]                          s_axil_arprot_i,
    input  logic                                s_axil_arvalid_i,
    output logic                                s_axil_arready_o,

    output logic [s_axil_data_width_p-1:0]      s_axil_rdata_o,
    output logic [1:0]                          s_axil_rresp_o,
    output logic                                s_axil_rvalid_o,
    input  logic                                s_axil_rready_i,

    output logic [7:0]                          tx_data_o,
    output logic                                tx_v_o,
    input  logic                                tx_ready_and_i,

    input  logic [7:0]                          rx_data_i,
    input  logic                                rx_v_i,
    output logic                                rx_ready_and_o
);

    localparam int unsigned pkt_width_lp   = 40;
    localparam int unsigned cnt_width_lp   = 3;
    localparam int unsigned timer_width_lp = $clog2(timeout_p + 1);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);
    localparam logic [1:0] resp_okay_lp   = 2'b00;
    localparam logic [1:0] resp_slverr_lp = 2'b10;

    if (s_axil_data_width_p != 32) begin : g_bad_data_width
        $error("s_axil_data_width_p must be 32");
    end
    if (timeout_p < 1) begin : g_bad_timeout
        $error("timeout_p must be at least 1");
    end

    typedef enum logic [2:0] {
        e_idle,
        e_wr_send,
        e_wr_resp,
        e_rd_send,
        e_rd_recv,
        e_rd_resp
    } state_e;

    state_e                      state_r, state_n;
    logic [pkt_width_lp-1:0]     shift_r;
    logic [cnt_width_lp-1:0]     byte_cnt_r;
    logic [timer_width_lp-1:0]   timer_r;
    logic [31:0]                 rdata_r;
    logic [1:0]                  bresp_r;
    logic [1:0]                  rresp_r;

    logic wr_req_c, wr_full_c;
    logic wr_accept_c, rd_accept_c;
    logic tx_fire_c, tx_last_c;
    logic rx_fire_c, rx_last_c;
    logic rd_timeout_c;

    // Protection bits and untransported address bits are dropped on purpose.
    logic unused_c;
    assign unused_c = ^{s_axil_awprot_i, s_axil_arprot_i, s_axil_awaddr_i, s_axil_araddr_i};

    assign wr_full_c = (s_axil_wstrb_i == 4'hF);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_idle;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n          = state_r;
        s_axil_awready_o = 1'b0;
        s_axil_wready_o  = 1'b0;
        s_axil_arready_o = 1'b0;
        s_axil_bvalid_o  = 1'b0;
        s_axil_rvalid_o  = 1'b0;
        tx_v_o           = 1'b0;
        rx_ready_and_o   = 1'b0;
        wr_req_c         = s_axil_awvalid_i & s_axil_wvalid_i;
        wr_accept_c      = 1'b0;
        rd_accept_c      = 1'b0;
        tx_fire_c        = 1'b0;
        tx_last_c        = 1'b0;
        rx_fire_c        = 1'b0;
        rx_last_c        = 1'b0;
        rd_timeout_c     = 1'b0;

        case (state_r)
            // Ready outputs are held low while reset is asserted; a write beats a read.
            e_idle: begin
                s_axil_awready_o = wr_req_c & reset_n_i;
                s_axil_wready_o  = wr_req_c & reset_n_i;
                s_axil_arready_o = s_axil_arvalid_i & ~wr_req_c & reset_n_i;
                rx_ready_and_o   = reset_n_i;
                if (wr_req_c & reset_n_i) begin
                    wr_accept_c = 1'b1;
                    state_n     = wr_full_c ? e_wr_send : e_wr_resp;
                end else if (s_axil_arvalid_i & reset_n_i) begin
                    rd_accept_c = 1'b1;
                    state_n     = e_rd_send;
                end
            end
            e_wr_send, e_rd_send: begin
                tx_v_o    = 1'b1;
                tx_fire_c = tx_ready_and_i;
                if (tx_ready_and_i && byte_cnt_r == 3'd4) begin
                    tx_last_c = 1'b1;
                    state_n   = (state_r == e_wr_send) ? e_wr_resp : e_rd_recv;
                end
            end
            e_wr_resp: begin
                s_axil_bvalid_o = 1'b1;
                if (s_axil_bready_i) state_n = e_idle;
            end
            e_rd_recv: begin
                rx_ready_and_o = 1'b1;
                rx_fire_c      = rx_v_i;
                if (rx_v_i && byte_cnt_r == 3'd3) begin
                    rx_last_c = 1'b1;
                    state_n   = e_rd_resp;
                end else if (timer_r == timer_last_lp) begin
                    rd_timeout_c = 1'b1;
                    state_n      = e_rd_resp;
                end
            end
            e_rd_resp: begin
                s_axil_rvalid_o = 1'b1;
                if (s_axil_rready_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    // Packet shifter, byte counter, read collector and response latches.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            shift_r    <= '0;
            byte_cnt_r <= '0;
            timer_r    <= '0;
            rdata_r    <= '0;
            bresp_r    <= '0;
            rresp_r    <= '0;
        end else begin
            if (wr_accept_c) begin
                bresp_r <= wr_full_c ? resp_okay_lp : resp_slverr_lp;
                if (wr_full_c) shift_r <= {s_axil_wdata_i[31:0], s_axil_awaddr_i[8:2], 1'b1};
            end
            if (rd_accept_c) shift_r <= {32'h0, s_axil_araddr_i[8:2], 1'b0};
            if (tx_fire_c) begin
                shift_r    <= {8'h00, shift_r[pkt_width_lp-1:8]};
                byte_cnt_r <= tx_last_c ? 3'd0 : byte_cnt_r + 3'd1;
            end
            if (rx_fire_c) begin
                rdata_r    <= {rx_data_i, rdata_r[31:8]};
                byte_cnt_r <= rx_last_c ? 3'd0 : byte_cnt_r + 3'd1;
            end
            if (rx_last_c) rresp_r <= resp_okay_lp;
            if (rd_timeout_c) begin
                rdata_r    <= '0;
                rresp_r    <= resp_slverr_lp;
                byte_cnt_r <= 3'd0;
            end
            timer_r <= (state_r == e_rd_recv) ? timer_r + timer_width_lp'(1) : '0;
        end
    end

    assign tx_data_o      = shift_r[7:0];
    assign s_axil_bresp_o = bresp_r;
    assign s_axil_rresp_o = rresp_r;
    assign s_axil_rdata_o = rdata_r;

endmodule

// File: tb/tb_bsg_zynq_uart_host_bridge.sv
// Directed bench for bsg_zynq_uart_host_bridge with hand-computed packets and responses.
module tb_bsg_zynq_uart_host_bridge;

    logic        clk_i;
    logic        reset_n_i;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  tx_data, rx_data;
    logic        tx_v, tx_ready, rx_v, rx_ready;

    int n_vec;
    int n_err;
    int hs;

    bsg_zynq_uart_host_bridge #(.timeout_p(16)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .s_axil_awaddr_i  (awaddr),
        .s_axil_awprot_i  (3'b000),
        .s_axil_awvalid_i (awvalid),
        .s_axil_awready_o (awready),
        .s_axil_wdata_i   (wdata),
        .s_axil_wstrb_i   (wstrb),
        .s_axil_wvalid_i  (wvalid),
        .s_axil_wready_o  (wready),
        .s_axil_bresp_o   (bresp),
        .s_axil_bvalid_o  (bvalid),
        .s_axil_bready_i  (bready),
        .s_axil_araddr_i  (araddr),
        .s_axil_arprot_i  (3'b000),
        .s_axil_arvalid_i (arvalid),
        .s_axil_arready_o (arready),
        .s_axil_rdata_o   (rdata),
        .s_axil_rresp_o   (rresp),
        .s_axil_rvalid_o  (rvalid),
        .s_axil_rready_i  (rready),
        .tx_data_o        (tx_data),
        .tx_v_o           (tx_v),
        .tx_ready_and_i   (tx_ready),
        .rx_data_i        (rx_data),
        .rx_v_i           (rx_v),
        .rx_ready_and_o   (rx_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks five consecutive TX bytes, one per cycle, starting the cycle after acceptance.
    task automatic expect_tx(input logic [39:0] pkt, input string tag);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i); #1;
            chk($sformatf("%s_txv%0d", tag, i), 32'(tx_v), 32'd1);
            chk($sformatf("%s_txd%0d", tag, i), 32'(tx_data), 32'(pkt[8*i +: 8]));
        end
    endtask

    task automatic feed_rx(input logic [31:0] w, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            rx_v    = 1'b1;
            rx_data = w[8*i +: 8];
            #1;
            chk($sformatf("%s_rxrdy%0d", tag, i), 32'(rx_ready), 32'd1);
        end
        @(negedge clk_i);
        rx_v = 1'b0;
        #1;
    endtask

    task automatic finish_b(input string tag, input logic [1:0] exp_resp);
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        bready = 1'b1;
        @(negedge clk_i); #1;
        bready = 1'b0;
        chk({tag, "_bdone"}, 32'(bvalid), 32'd0);
    endtask

    task automatic finish_r(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        @(negedge clk_i); #1;
        rready = 1'b0;
        chk({tag, "_rdone"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; hs = 0;
        reset_n_i = 1'b0;
        awaddr = '0; wdata = '0; araddr = '0; wstrb = '0; rx_data = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b0; rready = 1'b0; tx_ready = 1'b0; rx_v = 1'b0;

        // Reset state, with requests already pending
        #2;
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rxready", 32'(rx_ready), 32'd0);
        chk("rst_txv", 32'(tx_v), 32'd0);
        chk("rst_txdata", 32'(tx_data), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", 32'({bresp, rresp}), 32'd0);
        @(negedge clk_i);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        reset_n_i = 1'b1;
        #1;
        chk("rel_rxready", 32'(rx_ready), 32'd1);

        // Full-strobe write, TX always ready
        @(negedge clk_i);
        awaddr = 32'h104; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; tx_ready = 1'b1;
        #1;
        chk("w1_awready", 32'(awready), 32'd1);
        chk("w1_wready", 32'(wready), 32'd1);
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        expect_tx(40'hDEADBEEF83, "w1");
        @(negedge clk_i); #1;
        finish_b("w1", 2'b00);

        // Read with full-rate RX
        @(negedge clk_i);
        araddr = 32'h010; arvalid = 1'b1;
        #1;
        chk("r1_arready", 32'(arready), 32'd1);
        @(posedge clk_i); #1;
        arvalid = 1'b0;
        expect_tx(40'h0000000008, "r1");
        feed_rx(32'h12345678, 4, "r1");
        finish_r("r1", 32'h12345678, 2'b00);

        // Partial strobe write: no packet, SLVERR
        @(negedge clk_i);
        awaddr = 32'h020; wdata = 32'h55; wstrb = 4'h3;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        chk("we_awready", 32'(awready), 32'd1);
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk_i); #1;
        chk("we_txv", 32'(tx_v), 32'd0);
        finish_b("we", 2'b10);
        chk("we_txv_after", 32'(tx_v), 32'd0);

        // Simultaneous write and read: write first, read waits for bready
        @(negedge clk_i);
        awaddr = 32'h0FC; wdata = 32'h11223344; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h024; arvalid = 1'b1;
        #1;
        chk("sw_awready", 32'(awready), 32'd1);
        chk("sw_arready", 32'(arready), 32'd0);
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        expect_tx(40'h112233447F, "sw");
        @(negedge clk_i); #1;
        chk("sw_arready_busy", 32'(arready), 32'd0);
        finish_b("sw", 2'b00);
        chk("sr_arready", 32'(arready), 32'd1);
        @(posedge clk_i); #1;
        arvalid = 1'b0;
        expect_tx(40'h0000000012, "sr");
        feed_rx(32'hDDCCBBAA, 4, "sr");
        finish_r("sr", 32'hDDCCBBAA, 2'b00);

        // Reset after the 2nd TX byte under random backpressure
        @(negedge clk_i);
        awaddr = 32'h1FC; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; tx_ready = 1'b0;
        #1;
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            tx_ready = 1'($urandom_range(0, 1));
            #1;
            if (tx_v && tx_ready) hs++;
            if (hs == 2) break;
        end
        chk("rst_hs", 32'(hs), 32'd2);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        chk("mrst_txv", 32'(tx_v), 32'd0);
        chk("mrst_txdata", 32'(tx_data), 32'd0);
        chk("mrst_bvalid", 32'(bvalid), 32'd0);
        chk("mrst_rdata", rdata, 32'd0);
        chk("mrst_rxready", 32'(rx_ready), 32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1; tx_ready = 1'b1;
        #1;
        chk("mrst_rel_rxready", 32'(rx_ready), 32'd1);
        @(negedge clk_i);
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        @(posedge clk_i); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        expect_tx(40'hCAFEF00DFF, "rw");
        @(negedge clk_i); #1;
        finish_b("rw", 2'b00);

        // Read timeout with only 2 RX bytes (timeout_p = 16)
        @(negedge clk_i);
        araddr = 32'h004; arvalid = 1'b1;
        #1;
        @(posedge clk_i); #1;
        arvalid = 1'b0;
        expect_tx(40'h0000000002, "to");
        feed_rx(32'h00003412, 2, "to");
        for (int k = 8; k < 22; k++) begin
            chk($sformatf("to_wait%0d", k), 32'(rvalid), 32'd0);
            @(negedge clk_i); #1;
        end
        finish_r("to", 32'h0, 2'b10);

        // Late RX bytes discarded in idle, then a clean read
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            rx_v = 1'b1; rx_data = 8'hEE;
            #1;
            chk("stray_rxready", 32'(rx_ready), 32'd1);
            chk("stray_rvalid", 32'(rvalid), 32'd0);
        end
        @(negedge clk_i);
        rx_v = 1'b0;
        araddr = 32'h1F0; arvalid = 1'b1;
        #1;
        chk("r2_arready", 32'(arready), 32'd1);
        @(posedge clk_i); #1;
        arvalid = 1'b0;
        expect_tx(40'h00000000F8, "r2");
        feed_rx(32'h04030201, 4, "r2");
        finish_r("r2", 32'h04030201, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
